// File: rtl/riscv_lsu.sv
// Purpose : RISC-V load/store unit; aligns store data and byte enables, extracts and extends load data.
// Latency : zero-cycle combinational datapath; a single stall flop paces each request.
// Backpress: core_stall_o holds the core; each request stalls at least one cycle and
//            releases on the first later cycle with mem_ready_i = 1.
//
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   core_req_i/we_i     : core request, 1 = store / 0 = load
//   core_size_i         : 0=B 1=H 2=W 4=BU 5=HU (other codes unused)
//   core_addr_i/wd_i    : byte address, right-aligned store data
//   core_rd_o           : extended load data
//   core_stall_o        : core must hold the request
//   mem_req_o/we_o/be_o/addr_o/wd_o : memory request side
//   mem_rd_i/ready_i    : memory read data and completion
//
// Optional feature: define LSU_RD_GATE_EN to force core_rd_o to zero unless a load is requested.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  // Remembers that the previous cycle was a stalled request; this is the
  // only state in the unit.
  logic        r_stall_q;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rd;

  // Request passthrough.
  assign mem_req_o  = core_req_i;
  assign mem_we_o   = core_we_i;
  assign mem_addr_o = core_addr_i;

  // A fresh request (r_stall_q = 0) always stalls; a held request releases
  // as soon as memory reports ready. No request never stalls.
  assign core_stall_o = core_req_i & ~(r_stall_q & mem_ready_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_q <= 1'b0;
    end else begin
      r_stall_q <= core_stall_o;
    end
  end

  // Byte enables: alignment is not checked, low address bits are simply
  // ignored for halfword and word accesses.
  always_comb begin
    mem_be_o = 4'b1111;
    case (core_size_i)
      LDST_B:  mem_be_o = 4'b0001 << core_addr_i[1:0];
      LDST_H:  mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
      default: mem_be_o = 4'b1111;
    endcase
  end

  // Store data replicated across all lanes so the byte enables pick the lane.
  always_comb begin
    mem_wd_o = 32'd0;
    case (core_size_i)
      LDST_B:  mem_wd_o = {4{core_wd_i[7:0]}};
      LDST_H:  mem_wd_o = {2{core_wd_i[15:0]}};
      LDST_W:  mem_wd_o = core_wd_i;
      default: mem_wd_o = 32'd0;
    endcase
  end

  // Load lane extraction.
  always_comb begin
    w_byte = mem_rd_i[7:0];
    case (core_addr_i[1:0])
      2'd0: w_byte = mem_rd_i[7:0];
      2'd1: w_byte = mem_rd_i[15:8];
      2'd2: w_byte = mem_rd_i[23:16];
      2'd3: w_byte = mem_rd_i[31:24];
      default: w_byte = mem_rd_i[7:0];
    endcase
  end

  assign w_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  always_comb begin
    w_rd = 32'd0;
    case (core_size_i)
      LDST_B:  w_rd = {{24{w_byte[7]}}, w_byte};
      LDST_BU: w_rd = {24'd0, w_byte};
      LDST_H:  w_rd = {{16{w_half[15]}}, w_half};
      LDST_HU: w_rd = {16'd0, w_half};
      LDST_W:  w_rd = mem_rd_i;
      default: w_rd = 32'd0;
    endcase
  end

`ifdef LSU_RD_GATE_EN
  // Hold load data at zero unless a load is actually being requested.
  assign core_rd_o = (core_req_i && !core_we_i) ? w_rd : 32'd0;
`else
  assign core_rd_o = w_rd;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  riscv_lsu dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then move 1ns past it for driving.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i       = 1'b0;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b0;

    // Reset state
    step();
    check("rst_stall_idle", {31'd0, core_stall_o}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    // During reset stall_q stays 0, so a request stalls even with ready.
    core_req_i  = 1'b1;
    mem_ready_i = 1'b1;
    step();
    step();
    check("rst_req_stall", {31'd0, core_stall_o}, 32'd1);

    // Release reset with request and ready held: first cycle stalls.
    rst_i = 1'b1;
    settle();
    check("r33_cyc1", {31'd0, core_stall_o}, 32'd1);
    step();
    check("r33_cyc2", {31'd0, core_stall_o}, 32'd0);
    step();
    check("next_req_stalls", {31'd0, core_stall_o}, 32'd1);
    step(); // stall_q now 1
    core_req_i  = 1'b0;
    mem_ready_i = 1'b0;
    settle();
    check("noreq_nostall", {31'd0, core_stall_o}, 32'd0);
    step(); // stall_q back to 0

    // First cycle ignores ready, then 3 cycles not ready, then ready.
    core_req_i  = 1'b1;
    mem_ready_i = 1'b1;
    settle();
    check("r34_c1", {31'd0, core_stall_o}, 32'd1);
    step();
    mem_ready_i = 1'b0;
    settle();
    check("r34_c2", {31'd0, core_stall_o}, 32'd1);
    step();
    check("r34_c3", {31'd0, core_stall_o}, 32'd1);
    step();
    check("r34_c4", {31'd0, core_stall_o}, 32'd1);
    step();
    mem_ready_i = 1'b1;
    settle();
    check("r34_c5_release", {31'd0, core_stall_o}, 32'd0);
    step();
    core_req_i = 1'b0;
    step();

    // Loads (request active, load)
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_addr_i = 32'h0000_1002;
    mem_rd_i    = 32'h12F4_5678;
    core_size_i = 3'd0; settle();
    check("ld_b_a2", core_rd_o, 32'hFFFF_FFF4);
    check("mem_addr", mem_addr_o, 32'h0000_1002);
    check("mem_we_ld", {31'd0, mem_we_o}, 32'd0);
    core_size_i = 3'd4; settle();
    check("ld_bu_a2", core_rd_o, 32'h0000_00F4);
    core_addr_i = 32'h0000_1000; core_size_i = 3'd0; settle();
    check("ld_b_a0_pos", core_rd_o, 32'h0000_0078);
    core_addr_i = 32'h0000_1003; settle();
    check("ld_b_a3", core_rd_o, 32'h0000_0012);
    core_addr_i = 32'h0000_2002; mem_rd_i = 32'h8001_ABCD;
    core_size_i = 3'd1; settle();
    check("ld_h_a2", core_rd_o, 32'hFFFF_8001);
    core_size_i = 3'd5; settle();
    check("ld_hu_a2", core_rd_o, 32'h0000_8001);
    core_addr_i = 32'h0000_2001; core_size_i = 3'd1; settle();
    check("ld_h_a1_ignb0", core_rd_o, 32'hFFFF_ABCD);
    core_size_i = 3'd5; settle();
    check("ld_hu_a1", core_rd_o, 32'h0000_ABCD);
    core_addr_i = 32'h0000_2003; core_size_i = 3'd2; settle();
    check("ld_w_unaligned", core_rd_o, 32'h8001_ABCD);
    check("be_w", {28'd0, mem_be_o}, 32'h0000_000F);
    core_size_i = 3'd3; settle();
    check("ld_sz3", core_rd_o, 32'd0);
    core_size_i = 3'd7; settle();
    check("ld_sz7", core_rd_o, 32'd0);

    // Read data with no request
    core_req_i = 1'b0; core_size_i = 3'd2; settle();
`ifdef LSU_RD_GATE_EN
    check("rd_noreq", core_rd_o, 32'd0);
`else
    check("rd_noreq", core_rd_o, 32'h8001_ABCD);
`endif
    check("mem_req_pass", {31'd0, mem_req_o}, 32'd0);

    // Stores
    core_req_i  = 1'b1;
    core_we_i   = 1'b1;
    core_wd_i   = 32'hDEAD_BEEF;
    core_addr_i = 32'h0000_3003;
    core_size_i = 3'd0; settle();
    check("st_b_be", {28'd0, mem_be_o}, 32'h0000_0008);
    check("st_b_wd", mem_wd_o, 32'hEFEF_EFEF);
    check("mem_we_st", {31'd0, mem_we_o}, 32'd1);
`ifdef LSU_RD_GATE_EN
    check("rd_store_gated", core_rd_o, 32'd0);
`endif
    core_addr_i = 32'h0000_3001; settle();
    check("st_b_be_a1", {28'd0, mem_be_o}, 32'h0000_0002);
    core_wd_i = 32'h1234_ABCD; core_addr_i = 32'h0000_3000;
    core_size_i = 3'd1; settle();
    check("st_h_be", {28'd0, mem_be_o}, 32'h0000_0003);
    check("st_h_wd", mem_wd_o, 32'hABCD_ABCD);
    core_addr_i = 32'h0000_3003; settle();
    check("st_h_be_a3", {28'd0, mem_be_o}, 32'h0000_000C);
    core_size_i = 3'd2; core_addr_i = 32'h0000_3001; settle();
    check("st_w_wd", mem_wd_o, 32'h1234_ABCD);
    check("st_w_be", {28'd0, mem_be_o}, 32'h0000_000F);
    core_size_i = 3'd4; settle();
    check("st_bu_wd", mem_wd_o, 32'd0);
    check("st_bu_be", {28'd0, mem_be_o}, 32'h0000_000F);

    // Reset mid-stall
    core_req_i = 1'b0; core_we_i = 1'b0;
    step();
    step();
    core_req_i  = 1'b1;
    mem_ready_i = 1'b0;
    step(); // stall_q = 1
    check("mid_stall", {31'd0, core_stall_o}, 32'd1);
    mem_ready_i = 1'b1;
    settle();
    check("mid_would_release", {31'd0, core_stall_o}, 32'd0);
    rst_i = 1'b0;
    settle();
    check("async_clear", {31'd0, core_stall_o}, 32'd1);
    step();
    check("rst_hold", {31'd0, core_stall_o}, 32'd1);
    rst_i = 1'b1;
    settle();
    check("post_rst_cyc1", {31'd0, core_stall_o}, 32'd1);
    step();
    check("post_rst_cyc2", {31'd0, core_stall_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port core_req_i, input, 1 bit: core memory access request.
REQ-004 SHALL have port core_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port core_size_i, input, 3 bits: access size. B=3'd0, H=3'd1, W=3'd2, BU=3'd4, HU=3'd5 (riscv_pkg LDST_*).
REQ-006 SHALL have port core_addr_i, input, 32 bits: byte address.
REQ-007 SHALL have port core_wd_i, input, 32 bits: store data, right-aligned.
REQ-008 SHALL have port core_rd_o, output, 32 bits: load data, extended.
REQ-009 SHALL have port core_stall_o, output, 1 bit: core must hold the request.
REQ-010 SHALL have port mem_req_o, output, 1 bit: memory request.
REQ-011 SHALL have port mem_we_o, output, 1 bit: memory write enable.
REQ-012 SHALL have port mem_be_o, output, 4 bits: byte enables.
REQ-013 SHALL have port mem_addr_o, output, 32 bits: memory address.
REQ-014 SHALL have port mem_wd_o, output, 32 bits: memory write data.
REQ-015 SHALL have port mem_rd_i, input, 32 bits: memory read data.
REQ-016 SHALL have port mem_ready_i, input, 1 bit: memory access complete.

Function
REQ-017 SHALL drive mem_req_o = core_req_i, mem_we_o = core_we_i and mem_addr_o = core_addr_i combinationally.
REQ-018 SHALL hold one state flop, stall_q, loaded with core_stall_o on every clock edge.
REQ-019 SHALL drive core_stall_o = core_req_i & ~(stall_q & mem_ready_i).
REQ-020 Consequence of REQ-019: a new request always stalls in its first cycle; it releases in the first later cycle where mem_ready_i = 1; the following request stalls again.
REQ-021 SHALL drive core_stall_o = 0 whenever core_req_i = 0, whatever stall_q is.
REQ-022 SHALL drive mem_be_o as follows:
  - B: 4'b0001 << addr[1:0].
  - H: 4'b0011 when addr[1] = 0; 4'b1100 when addr[1] = 1.
  - Every other size, W included: 4'b1111.
REQ-023 SHALL drive mem_wd_o as follows:
  - B: core_wd_i[7:0] replicated four times.
  - H: core_wd_i[15:0] replicated twice.
  - W: core_wd_i.
  - Every other size: 32'd0.
REQ-024 SHALL drive core_rd_o for B and BU from byte addr[1:0] of mem_rd_i; B sign-extends it, BU zero-extends it.
REQ-025 SHALL drive core_rd_o for H and HU from halfword addr[1] of mem_rd_i; H sign-extends it, HU zero-extends it.
REQ-026 SHALL drive core_rd_o = mem_rd_i for W and 32'd0 for unused size codes 3, 6 and 7.
REQ-027 SHALL not check alignment; addr bit 0 is ignored for halfword accesses and addr[1:0] is ignored for word accesses.
REQ-028 All outputs except the stall_q dependency SHALL be purely combinational, with zero-cycle latency.

Reset
REQ-029 SHALL clear stall_q to 0 asynchronously while rst_i = 0; the clear holds until rst_i = 1.
REQ-030 Reset during a stalled access SHALL abort it; after release, the next request stalls as a new request.
REQ-031 No other state SHALL exist; all other outputs follow their inputs during reset.

Configuration
REQ-032 Macro LSU_RD_GATE_EN SHALL control read-data gating.
  - When defined: core_rd_o = 32'd0 unless core_req_i = 1 and core_we_i = 0.
  - When undefined: core_rd_o follows REQ-024 to REQ-026 unconditionally.

Verification
REQ-033 Reset, then core_req_i = 1 with mem_ready_i = 1: cycle 1 core_stall_o = 1; cycle 2 core_stall_o = 0.
REQ-034 Request held while mem_ready_i = 0 for 3 cycles, then 1: core_stall_o = 1 for 4 cycles, then 0.
REQ-035 Load B, addr 0x...2, mem_rd_i = 0x12F45678: core_rd_o = 0xFFFFFFF4. Same with BU: core_rd_o = 0x000000F4.
REQ-036 Load H, addr 0x...2, mem_rd_i = 0x8001ABCD: core_rd_o = 0xFFFF8001. Same with HU: core_rd_o = 0x00008001.
REQ-037 Store B, addr 0x...3, core_wd_i = 0xDEADBEEF: mem_be_o = 4'b1000, mem_wd_o = 0xEFEFEFEF.
REQ-038 Store H, addr 0x...0, core_wd_i = 0x1234ABCD: mem_be_o = 4'b0011, mem_wd_o = 0xABCDABCD.
REQ-039 Drive rst_i low mid-stall: core_stall_o reverts to the first-cycle behaviour after release.
